// File: rtl/mod_add_arbiter.sv
// Round-robin front end sharing one secp256k1 adder R = (A + B) mod p among N_REQ requesters.
// Latency 2 cycles handshake->rsp_valid; no response backpressure, grants stall only on hold.
module mod_add_arbiter #(
    parameter int             N_REQ   = 4,
    parameter int             W       = 256,
    parameter logic [W-1:0]   P_CONST = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [W-1:0]         rsp_r,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef struct packed {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [IDW-1:0] id;
        logic           err;
    } op_t;

    typedef struct packed {
        logic [W-1:0]   r;
        logic [IDW-1:0] id;
        logic           err;
    } rsp_t;

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           s1_vld_q, s1_vld_d;
    op_t            s1_q, s1_d;
    logic           s2_vld_q, s2_vld_d;
    rsp_t           s2_q, s2_d;

    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_id;
    logic             grant_vld;
    logic [IDW:0]     scan_w;
    logic [IDW-1:0]   scan_idx;

    // Scan from the pointer upward with wrap; first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_vld = 1'b0;
        scan_w    = '0;
        scan_idx  = '0;
        if (!hold && rst_n) begin
            for (int k = 0; k < N_REQ; k++) begin
                scan_w = {1'b0, rr_ptr_q} + (IDW+1)'(k);
                if (scan_w >= (IDW+1)'(N_REQ)) begin
                    scan_w = scan_w - (IDW+1)'(N_REQ);
                end
                scan_idx = scan_w[IDW-1:0];
                if (!grant_vld && req_valid[scan_idx]) begin
                    grant_vld = 1'b1;
                    grant_id  = scan_idx;
                end
            end
        end
        if (grant_vld) begin
            grant[grant_id] = 1'b1;
        end
    end

    assign req_ready = grant;

    logic [W-1:0] sel_a, sel_b;
    assign sel_a = req_a[int'(grant_id)*W +: W];
    assign sel_b = req_b[int'(grant_id)*W +: W];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        s1_vld_d = grant_vld;
        s1_d     = s1_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_id == IDW'(N_REQ-1)) ? '0 : grant_id + 1'b1;
            s1_d.a   = sel_a;
            s1_d.b   = sel_b;
            s1_d.id  = grant_id;
            s1_d.err = (sel_a >= P_CONST) | (sel_b >= P_CONST);
        end
    end

    // Single conditional subtraction; low W bits of (sum - p) equal sum[W-1:0] - p mod 2^W.
    logic [W:0]   sum;
    logic [W-1:0] red;
    always_comb begin
        sum      = {1'b0, s1_q.a} + {1'b0, s1_q.b};
        red      = (sum >= {1'b0, P_CONST}) ? (sum[W-1:0] - P_CONST) : sum[W-1:0];
        s2_vld_d = s1_vld_q;
        s2_d     = s2_q;
        if (s1_vld_q) begin
            s2_d.r   = red;
            s2_d.id  = s1_q.id;
            s2_d.err = s1_q.err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
            s2_vld_q <= 1'b0;
            s2_q     <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            s1_vld_q <= s1_vld_d;
            s1_q     <= s1_d;
            s2_vld_q <= s2_vld_d;
            s2_q     <= s2_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (s2_vld_q) begin
            rsp_valid[s2_q.id] = 1'b1;
        end
    end

    assign rsp_r   = s2_q.r;
    assign rsp_err = s2_q.err;
    assign busy    = s1_vld_q | s2_vld_q | (|req_valid);

endmodule

// File: tb/tb_mod_add_arbiter.sv
// Randomized and directed bench for mod_add_arbiter against a transaction-level model.
module tb_mod_add_arbiter;
    localparam int N = 4;
    localparam int W = 256;
    localparam logic [W-1:0] P   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [W-1:0] PM2 = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2D;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             hold = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     rsp_valid;
    logic [W-1:0]     rsp_r;
    logic             rsp_err;
    logic             busy;

    always #5 clk = ~clk;

    mod_add_arbiter #(.N_REQ(N), .W(W), .P_CONST(P)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_r(rsp_r),
        .rsp_err(rsp_err), .busy(busy)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    // Transaction-level model: expected responses keyed by the cycle they must appear in.
    typedef struct {
        int           due;
        int           id;
        logic [W-1:0] r;
        logic         err;
    } exp_t;

    exp_t         pipe[$];
    int           grants[$];
    int           m_ptr = 0;
    logic [W-1:0] m_last_r = '0;
    logic         m_last_err = 1'b0;
    logic [N-1:0] hs = '0;
    logic [W-1:0] seen_r = '0;
    logic         seen_err = 1'b0;
    logic [N-1:0] seen_vld = '0;

    function automatic logic [W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
        case ($urandom_range(0, 3))
            1: v = P - W'($urandom_range(1, 255));
            2: v = P + W'($urandom_range(0, 255));
            3: v = W'($urandom_range(0, 1000));
            default: ;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        pipe.delete();
        m_ptr      = 0;
        m_last_r   = '0;
        m_last_err = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i]    = 1'b1;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // One clock cycle: check at negedge, update the model, return at posedge+1 for driving.
    task automatic step();
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_vld;
        logic         exp_busy;
        int           g;
        exp_t         e;
        exp_rdy = '0;
        exp_vld = '0;
        g = -1;
        @(negedge clk);
        if (rst_n && !hold) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_busy = |req_valid;
        foreach (pipe[q]) if (pipe[q].due == cyc || pipe[q].due == cyc + 1) exp_busy = 1'b1;
        if (pipe.size() > 0 && pipe[0].due == cyc) begin
            e = pipe.pop_front();
            exp_vld[e.id] = 1'b1;
            m_last_r   = e.r;
            m_last_err = e.err;
        end
        check_eq("req_ready", W'(req_ready), W'(exp_rdy));
        check_eq("rsp_valid", W'(rsp_valid), W'(exp_vld));
        check_eq("rsp_r", rsp_r, m_last_r);
        check_eq("rsp_err", W'(rsp_err), W'(m_last_err));
        check_eq("busy", W'(busy), W'(exp_busy));
        if (rsp_valid != '0) begin
            seen_r   = rsp_r;
            seen_err = rsp_err;
            seen_vld = rsp_valid;
        end
        if (g >= 0) begin
            e.due = cyc + 2;
            e.id  = g;
            e.r   = ref_add(req_a[g*W +: W], req_b[g*W +: W]);
            e.err = (req_a[g*W +: W] >= P) || (req_b[g*W +: W] >= P);
            pipe.push_back(e);
            m_ptr = (g + 1) % N;
            grants.push_back(g);
        end
        hs = exp_rdy;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        model_reset();
        step();
        rst_n = 1'b1;
    endtask

    // Issue a single op from requester i and run until its response cycle.
    task automatic run_one(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        set_req(i, a, b);
        step();
        req_valid[i] = 1'b0;
        step();
        step();
    endtask

    initial begin
        #1;
        rst_n = 1'b0;
        model_reset();
        step();
        step();
        check_eq("rst_rsp_r", rsp_r, '0);
        check_eq("rst_rsp_err", W'(rsp_err), '0);
        check_eq("rst_rsp_valid", W'(rsp_valid), '0);
        check_eq("rst_req_ready", W'(req_ready), '0);
        rst_n = 1'b1;
        step();

        run_one(0, W'(2), W'(3));
        check_eq("tp_2p3_r", seen_r, W'(5));
        check_eq("tp_2p3_vld", W'(seen_vld), W'(4'b0001));
        check_eq("tp_2p3_err", W'(seen_err), '0);

        run_one(1, P - 1, W'(1));
        check_eq("tp_pm1p1_r", seen_r, '0);
        run_one(1, P - 1, P - 1);
        check_eq("tp_pm1pm1_r", seen_r, PM2);
        check_eq("tp_pm1pm1_err", W'(seen_err), '0);

        // All four requesters valid straight out of reset.
        do_reset();
        grants.delete();
        for (int i = 0; i < N; i++) set_req(i, rand_op(), rand_op());
        for (int s = 0; s < 6; s++) begin
            step();
            req_valid = req_valid & ~hs;
        end
        for (int i = 0; i < N; i++) check_eq("rr_order", W'(grants[i]), W'(i));

        run_one(2, P, W'(0));
        check_eq("tp_p0_r", seen_r, '0);
        check_eq("tp_p0_err", W'(seen_err), W'(1));
        run_one(2, W'(1), W'(1));
        check_eq("tp_11_r", seen_r, W'(2));
        check_eq("tp_11_err", W'(seen_err), '0);

        // hold blocks grants while busy stays high.
        hold = 1'b1;
        set_req(3, W'(7), W'(9));
        for (int s = 0; s < 5; s++) step();
        hold = 1'b0;
        grants.delete();
        step();
        check_eq("hold_release_grant", W'(grants.size()), W'(1));
        req_valid[3] = 1'b0;
        step();
        step();
        check_eq("hold_rsp_r", seen_r, W'(16));

        // Reset kills an in-flight op and resets the pointer.
        set_req(1, W'(11), W'(22));
        step();
        req_valid[1] = 1'b0;
        do_reset();
        step();
        step();
        check_eq("rst_flight_r", rsp_r, '0);
        grants.delete();
        for (int i = 0; i < N; i++) set_req(i, rand_op(), rand_op());
        step();
        req_valid = req_valid & ~hs;
        check_eq("rst_first_grant", W'(grants[0]), '0);

        // Randomized traffic with holds, withdrawals and rare resets.
        for (int c = 0; c < 3000; c++) begin
            hold = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    if ($urandom_range(0, 1) == 0) set_req(i, rand_op(), rand_op());
                    else req_valid[i] = 1'b0;
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) set_req(i, rand_op(), rand_op());
                end else if ($urandom_range(0, 31) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            else step();
        end

        hold = 1'b0;
        req_valid = '0;
        for (int s = 0; s < 4; s++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
